// File: rtl/mmio_display_port.sv
// Memory-mapped display port: core stores to one address are queued in a small
// FIFO and handed one at a time to a binary-to-decimal converter with a dwell.
module mmio_display_port #(
    parameter logic [31:0] DISP_ADDR   = 32'h0000_0400,
    parameter int          DEPTH       = 4,
    parameter int          HOLD_CYCLES = 100_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [31:0]              wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     complete,
    input  logic                     clr_ovf,
    output logic [31:0]              decimal,
    output logic                     load_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO   = AW'(0);
    localparam logic [CW-1:0] DWELL_ZERO = CW'(0);
    localparam logic [CW-1:0] DWELL_ONE  = CW'(1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        WAIT_LOW = 3'd2,
        WAIT_CPL = 3'd3,
        HOLD     = 3'd4
    } state_t;

    state_t        state_r;
    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] dwell_r;

    logic          push_s;
    logic          pop_s;
    logic          drop_s;
    logic          accept_s;
    logic [AW:0]   count_next_s;

    // Push/pop decode; a push at full survives only if the head leaves in the same cycle
    always_comb begin
        push_s       = wr_en && (wr_addr == DISP_ADDR);
        pop_s        = (state_r == IDLE) && (fifo_count != COUNT_ZERO);
        drop_s       = push_s && fifo_full && !pop_s;
        accept_s     = push_s && !drop_s;
        count_next_s = fifo_count;
        if (accept_s && !pop_s) begin
            count_next_s = fifo_count + COUNT_ONE;
        end else if (pop_s && !accept_s) begin
            count_next_s = fifo_count - COUNT_ONE;
        end else begin
            count_next_s = fifo_count;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clock) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow (set beats clear)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            fifo_count <= COUNT_ZERO;
            fifo_full  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            fifo_count <= count_next_s;
            fifo_full  <= (count_next_s == FULL_COUNT);
            if (drop_s) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Converter handshake: pop, pulse load, wait out a stale complete, wait done, dwell
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            decimal   <= 32'd0;
            load_data <= 1'b0;
            dwell_r   <= DWELL_ZERO;
        end else begin
            load_data <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        decimal <= mem_r[rd_ptr_r];
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    load_data <= 1'b1;
                    state_r   <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!complete) begin
                        state_r <= WAIT_CPL;
                    end
                end
                WAIT_CPL: begin
                    if (complete) begin
                        if (HOLD_CYCLES == 0) begin
                            state_r <= IDLE;
                        end else begin
                            dwell_r <= DWELL_LOAD;
                            state_r <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dwell_r == DWELL_ZERO) begin
                        state_r <= IDLE;
                    end else begin
                        dwell_r <= dwell_r - DWELL_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
